// File: rtl/bcd_down_counter.sv
// ============================================================================
//  Module      : bcd_down_counter
//  Description : Cascadable multi-digit BCD down counter with load and
//                terminal-count borrow output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_counter #(
    parameter int DIGITS       = 2,
    parameter bit STOP_AT_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic [4*DIGITS-1:0]   q_bar,
    output logic                  zero,
    output logic                  borrow_out
);

    localparam int         c_WIDTH = 4 * DIGITS;
    localparam logic [3:0] c_NINE  = 4'd9;

    logic [c_WIDTH-1:0] r_q;
    logic [c_WIDTH-1:0] w_next;
    logic               w_all_zero;
    logic               w_lower_zero;
    logic [3:0]         w_dig;

    assign w_all_zero = (r_q == '0);

    always_comb begin
        w_next       = r_q;
        w_lower_zero = 1'b1;
        w_dig        = 4'd0;
        if (load) begin
            // Out-of-range preset digits saturate so no illegal BCD is ever stored.
            for (int i = 0; i < DIGITS; i++) begin
                w_dig = load_val[4*i +: 4];
                w_next[4*i +: 4] = (w_dig > c_NINE) ? c_NINE : w_dig;
            end
        end else if (en && !(STOP_AT_ZERO && w_all_zero)) begin
            // A digit only steps when every less-significant digit is zero.
            for (int i = 0; i < DIGITS; i++) begin
                w_dig = r_q[4*i +: 4];
                if (w_lower_zero) begin
                    w_next[4*i +: 4] = (w_dig == 4'd0) ? c_NINE : (w_dig - 4'd1);
                end
                w_lower_zero = w_lower_zero & (w_dig == 4'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign q          = r_q;
    assign q_bar      = ~r_q;
    assign zero       = w_all_zero;
    assign borrow_out = en & ~load & clear & w_all_zero;

endmodule

`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
// Directed checks of bcd_down_counter: reset, wrap, stop-at-zero, load
// saturation, two-stage cascade and a short modelled random run.
`default_nettype none

module tb_bcd_down_counter;

    logic       clk;
    logic       clear;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] q, q_bar, qs, qs_bar;
    logic       zero, borrow_out, zs, bs;

    logic       ch_en, ch_load;
    logic [7:0] ch_val;
    logic [7:0] lo_q, lo_qb, hi_q, hi_qb;
    logic       lo_z, lo_b, hi_z, hi_b;

    int checks = 0;
    int errors = 0;

    bcd_down_counter #(.DIGITS(2), .STOP_AT_ZERO(1'b0)) dut (
        .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
        .q(q), .q_bar(q_bar), .zero(zero), .borrow_out(borrow_out)
    );

    bcd_down_counter #(.DIGITS(2), .STOP_AT_ZERO(1'b1)) dut_s (
        .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
        .q(qs), .q_bar(qs_bar), .zero(zs), .borrow_out(bs)
    );

    bcd_down_counter #(.DIGITS(2), .STOP_AT_ZERO(1'b0)) dut_lo (
        .clk(clk), .clear(clear), .en(ch_en), .load(ch_load), .load_val(ch_val),
        .q(lo_q), .q_bar(lo_qb), .zero(lo_z), .borrow_out(lo_b)
    );

    bcd_down_counter #(.DIGITS(2), .STOP_AT_ZERO(1'b0)) dut_hi (
        .clk(clk), .clear(clear), .en(lo_b), .load(ch_load), .load_val(ch_val),
        .q(hi_q), .q_bar(hi_qb), .zero(hi_z), .borrow_out(hi_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    logic [7:0] exp_wrap [13];
    logic [7:0] exp_stop [5];
    int         model;
    int         d1, d0;
    logic       exp_b;

    initial begin
        exp_wrap = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05,
                     8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};
        exp_stop = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

        clear = 1'b0; en = 1'b0; load = 1'b0; load_val = 8'h00;
        ch_en = 1'b0; ch_load = 1'b0; ch_val = 8'h00;
        #2;
        check("reset_q", q, 8'h00);
        check("reset_qbar", q_bar, 8'hFF);
        check("reset_zero", zero, 1'b1);
        check("reset_borrow", borrow_out, 1'b0);

        // Async clear in the middle of a count
        @(negedge clk); clear = 1'b1;
        load = 1'b1; load_val = 8'h47;
        step();
        check("load47", q, 8'h47);
        load = 1'b0; en = 1'b1;
        step();
        check("dec46", q, 8'h46);
        #1 clear = 1'b0;
        #1;
        check("async_q", q, 8'h00);
        check("async_qbar", q_bar, 8'hFF);
        check("async_zero", zero, 1'b1);
        check("async_borrow_gated", borrow_out, 1'b0);
        en = 1'b0; clear = 1'b1;
        step();
        check("post_release_hold", q, 8'h00);

        // Wrap sequence from 12
        load = 1'b1; load_val = 8'h12;
        step();
        check("load12", q, 8'h12);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            check("wrap_borrow", borrow_out, (i == 12) ? 1'b1 : 1'b0);
            step();
            check("wrap_q", q, exp_wrap[i]);
        end
        check("wrap_qbar", q_bar, 8'h66);
        check("wrap_zero", zero, 1'b0);

        // Stop-at-zero instance
        en = 1'b0; load = 1'b1; load_val = 8'h02;
        step();
        check("stop_load", qs, 8'h02);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stop_borrow", bs, (i >= 2) ? 1'b1 : 1'b0);
            step();
            check("stop_q", qs, exp_stop[i]);
            check("stop_zero", zs, (i >= 1) ? 1'b1 : 1'b0);
        end

        // Load priority and digit saturation
        load = 1'b1; en = 1'b1; load_val = 8'h3C;
        step();
        check("load_prio_sat", q, 8'h39);
        load_val = 8'hFA;
        step();
        check("sat_both", q, 8'h99);
        load_val = 8'hA5;
        step();
        check("sat_hi", q, 8'h95);
        load_val = 8'h00;
        step();
        check("load_zero", q, 8'h00);
        check("borrow_masked_by_load", borrow_out, 1'b0);
        load = 1'b0; en = 1'b0;
        check("borrow_no_en", borrow_out, 1'b0);

        // Cascade of two stages
        ch_load = 1'b1; ch_val = 8'h00;
        step();
        check("chain_lo_load", lo_q, 8'h00);
        check("chain_hi_load", hi_q, 8'h00);
        ch_load = 1'b0; ch_en = 1'b1;
        #1;
        check("chain_lo_borrow", lo_b, 1'b1);
        check("chain_hi_borrow", hi_b, 1'b1);
        step();
        check("chain_lo_wrap", lo_q, 8'h99);
        check("chain_hi_wrap", hi_q, 8'h99);
        check("chain_lo_borrow_off", lo_b, 1'b0);
        step();
        check("chain_lo_dec", lo_q, 8'h98);
        check("chain_hi_hold", hi_q, 8'h99);
        ch_en = 1'b0;

        // Short random run against an integer model
        load = 1'b1; en = 1'b0; load_val = 8'h50;
        step();
        model = 50;
        for (int c = 0; c < 400; c++) begin
            load     = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            load_val = 8'($urandom);
            #1;
            exp_b = en && !load && (model == 0);
            check("rand_borrow", borrow_out, exp_b);
            if (load) begin
                d1 = (load_val[7:4] > 4'd9) ? 9 : int'(load_val[7:4]);
                d0 = (load_val[3:0] > 4'd9) ? 9 : int'(load_val[3:0]);
                model = d1 * 10 + d0;
            end else if (en) begin
                model = (model == 0) ? 99 : model - 1;
            end
            step();
            check("rand_q", q, to_bcd(model));
            check("rand_zero", zero, (model == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
